// File: rtl/rf_seq_pkg.sv
// ============================================================================
// rf_seq_pkg : shared types and default constants for the RF self-test sequencer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rf_seq_pkg;

  localparam int NREGS_D = 32;
  localparam int AW_D    = 5;
  localparam int DW_D    = 32;
  localparam int ERR_W   = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_CHK  = 3'd3,
    DONE    = 3'd4
  } state_t;

`ifdef RFSEQ_INV_PASS_EN
  // 0 = plain pattern pass, 1 = complemented pattern pass
  typedef logic pass_idx_t;
`endif

endpackage

`default_nettype wire

// File: rtl/rf_seq_pattern.sv
// ============================================================================
// rf_seq_pattern : expected register contents, (addr*MULT) mod 2^DW, optionally inverted
// Revision       : 1.0
// ============================================================================
`default_nettype none

module rf_seq_pattern #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int MULT = 10
) (
  input  logic [AW-1:0] addr,
  input  logic          invert,
  output logic [DW-1:0] expected
);

  logic [DW-1:0] prod;

  assign prod     = DW'(addr) * DW'(MULT);
  assign expected = invert ? ~prod : prod;

endmodule

`default_nettype wire

// File: rtl/rf_selftest_seq.sv
// ============================================================================
// rf_selftest_seq : register-file BIST, writes k*MULT to every register then
//                   reads back in pairs. Macro RFSEQ_INV_PASS_EN adds an inverted pass.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module rf_selftest_seq
  import rf_seq_pkg::*;
#(
  parameter int NREGS = NREGS_D,
  parameter int AW    = AW_D,
  parameter int DW    = DW_D,
  parameter int MULT  = 10
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    fail_addr,
  output logic [AW-1:0]    a1,
  output logic [AW-1:0]    a2,
  output logic [AW-1:0]    ad,
  output logic [DW-1:0]    di,
  output logic             we,
  input  logic [DW-1:0]    do1,
  input  logic [DW-1:0]    do2
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t             state, state_n;
  logic               busy_n, done_n, pass_n, we_n;
  logic [ERR_W-1:0]   err_count_n;
  logic [AW-1:0]      fail_addr_n, a1_n, a2_n, ad_n;
  logic [DW-1:0]      di_n;
  logic [DW-1:0]      exp_wr, exp1, exp2;
  logic               mis1, mis2;
  logic [ERR_W:0]     err_sum;
  logic [ERR_W-1:0]   err_sat;
  logic [AW-1:0]      ad_inc;

`ifdef RFSEQ_INV_PASS_EN
  pass_idx_t inv, inv_n;
`else
  logic inv;
  assign inv = 1'b0;
`endif

  assign ad_inc = ad + AW'(1);

  rf_seq_pattern #(.AW(AW), .DW(DW), .MULT(MULT)) u_pat_wr (
    .addr(ad_inc), .invert(inv), .expected(exp_wr)
  );
  rf_seq_pattern #(.AW(AW), .DW(DW), .MULT(MULT)) u_pat_a1 (
    .addr(a1), .invert(inv), .expected(exp1)
  );
  rf_seq_pattern #(.AW(AW), .DW(DW), .MULT(MULT)) u_pat_a2 (
    .addr(a2), .invert(inv), .expected(exp2)
  );

  assign mis1    = (do1 != exp1);
  assign mis2    = (do2 != exp2);
  assign err_sum = {1'b0, err_count} + (ERR_W+1)'(mis1) + (ERR_W+1)'(mis2);
  assign err_sat = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      a1        <= '0;
      a2        <= '0;
      ad        <= '0;
      di        <= '0;
      we        <= 1'b0;
`ifdef RFSEQ_INV_PASS_EN
      inv       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_count_n;
      fail_addr <= fail_addr_n;
      a1        <= a1_n;
      a2        <= a2_n;
      ad        <= ad_n;
      di        <= di_n;
      we        <= we_n;
`ifdef RFSEQ_INV_PASS_EN
      inv       <= inv_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    busy_n      = busy;
    done_n      = done;
    pass_n      = pass;
    err_count_n = err_count;
    fail_addr_n = fail_addr;
    a1_n        = a1;
    a2_n        = a2;
    ad_n        = ad;
    di_n        = di;
    we_n        = we;
`ifdef RFSEQ_INV_PASS_EN
    inv_n       = inv;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = WRITE;
          busy_n      = 1'b1;
          done_n      = 1'b0;
          pass_n      = 1'b0;
          err_count_n = '0;
          fail_addr_n = '0;
          ad_n        = '0;
          di_n        = '0;
          we_n        = 1'b1;
`ifdef RFSEQ_INV_PASS_EN
          inv_n       = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (ad == LAST) begin
          we_n    = 1'b0;
          a1_n    = '0;
          a2_n    = AW'(1);
          state_n = RD_CHK;
        end else begin
          ad_n = ad_inc;
          di_n = exp_wr;
        end
      end
      RD_CHK: begin
        err_count_n = err_sat;
        // Only the first failing register is recorded; saturation keeps err_count nonzero.
        if (err_count == '0 && (mis1 || mis2))
          fail_addr_n = mis1 ? a1 : a2;
        state_n = RD_ADDR;
      end
      RD_ADDR: begin
        if (a2 == LAST) begin
`ifdef RFSEQ_INV_PASS_EN
          if (!inv) begin
            inv_n   = 1'b1;
            ad_n    = '0;
            di_n    = '1;
            we_n    = 1'b1;
            state_n = WRITE;
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_count == '0);
          end
`else
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_count == '0);
`endif
        end else begin
          a1_n    = a1 + AW'(2);
          a2_n    = a2 + AW'(2);
          state_n = RD_CHK;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

`default_nettype wire
